uart_receiver: RTL and testbench

UART receive engine for the lab-2 serial link: it recovers 8-bit frames from the asynchronous `RxD` line using the 16x oversampling tick produced by the baud controller. It sits beside the transmitter, fed by the same baud controller instance, and hands each good byte to the consumer as a one-cycle valid pulse with sticky error flags. Its behaviour includes a start-bit FSM, 3-sample majority voting per bit, even-parity checking and framing checking.

---
 rtl/uart_receiver.sv | 146 ++++++++++++++
 tb/tb_uart_receiver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive engine: 16x oversampled, 3-sample majority vote, 8 data bits LSB first.
// Define UART_RX_PARITY_EN for an 8E1 frame (even parity); otherwise the frame is 8N1.
module uart_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_ENABLE,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic       armed;
    logic       rxd_m, rxd_s;
    logic       smp7, smp8;
    logic [7:0] shreg;
    logic       maj;
    logic       perr_now;

`ifdef UART_RX_PARITY_EN
    logic       perr_pend, perr_q;
    assign perr_now  = perr_pend;
    assign Rx_PERROR = perr_q;
`else
    assign perr_now  = 1'b0;
    assign Rx_PERROR = 1'b0;
`endif

    // samples at cnt 7 and 8 are registered; the cnt 9 sample is the live value
    assign maj = (smp7 & smp8) | (smp7 & rxd_s) | (smp8 & rxd_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RxD;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bit_idx   <= 3'd0;
            armed     <= 1'b0;
            smp7      <= 1'b0;
            smp8      <= 1'b0;
            shreg     <= 8'h00;
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_pend <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state <= IDLE;
                cnt   <= 4'd0;
                armed <= 1'b0;
            end else if (sample_ENABLE) begin
                if (cnt == 4'd7) smp7 <= rxd_s;
                if (cnt == 4'd8) smp8 <= rxd_s;
                cnt <= cnt + 4'd1;
                case (state)
                    IDLE: begin
                        cnt <= 4'd0;
                        if (rxd_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            // the detect tick itself is cnt 0 of the start bit
                            state   <= START;
                            cnt     <= 4'd1;
                            bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            perr_pend <= 1'b0;
`endif
                        end
                    end
                    START: begin
                        if (cnt == 4'd9 && maj) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else if (cnt == 4'd15) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (cnt == 4'd9) shreg <= {maj, shreg[7:1]};
                        if (cnt == 4'd15) begin
                            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                            if (bit_idx == 3'd7) state <= PARITY;
`else
                            if (bit_idx == 3'd7) state <= STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == 4'd9) perr_pend <= maj ^ (^shreg);
                        if (cnt == 4'd15) state <= STOP;
                    end
`endif
                    STOP: begin
                        // complete mid-stop so the next start edge is never missed
                        if (cnt == 4'd9) begin
                            state     <= IDLE;
                            cnt       <= 4'd0;
                            armed     <= maj;
                            Rx_FERROR <= ~maj;
`ifdef UART_RX_PARITY_EN
                            perr_q    <= perr_pend;
`endif
                            if (maj && !perr_now) begin
                                Rx_DATA  <= shreg;
                                Rx_VALID <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_receiver;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int LAT = 169;
`else
    localparam bit PAR = 1'b0;
    localparam int LAT = 153;
`endif

    logic       clk = 1'b0;
    logic       rst, sample_ENABLE, Rx_EN, RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

    int checks = 0, errors = 0;
    int tick_no = 0, vcount = 0, vtick = -1, div = 27;
    logic [7:0] exp_data = 8'h00;
    logic       exp_perr = 1'b0, exp_ferr = 1'b0;

    uart_receiver dut (
        .clk(clk), .rst(rst), .sample_ENABLE(sample_ENABLE), .Rx_EN(Rx_EN), .RxD(RxD),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
    );

    always #5 clk = ~clk;

    // one-cycle tick every 'div' clocks; tick_no counts tick edges
    initial begin
        sample_ENABLE = 1'b0;
        forever begin
            repeat (div - 1) @(negedge clk);
            sample_ENABLE = 1'b1;
            @(posedge clk);
            tick_no++;
            @(negedge clk);
            sample_ENABLE = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (Rx_VALID === 1'b1) begin
            vcount++;
            vtick = tick_no;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        int t0 = tick_no;
        int n = 0;
        while (tick_no == t0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tick_no == t0) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick want tick");
        end
    endtask

    // hold level b for n ticks, inverting it for the single tick at index gc
    task automatic drive(input logic b, input int n, input int gc);
        for (int c = 0; c < n; c++) begin
            RxD = (c == gc) ? ~b : b;
            next_tick();
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"}, 32'(Rx_DATA), 32'(exp_data));
        check({tag, ".perr"}, 32'(Rx_PERROR), 32'(exp_perr));
        check({tag, ".ferr"}, 32'(Rx_FERROR), 32'(exp_ferr));
    endtask

    task automatic frame(input logic [7:0] d, input bit pflip, input bit stop,
                         input int gbit, input int gc, input int idle, input string tag);
        int   v0    = vcount;
        int   t_dec = tick_no + 1 + LAT;
        logic perr  = PAR & pflip;
        logic good  = stop & ~perr;
        drive(1'b0, 16, -1);
        for (int i = 0; i < 8; i++) drive(d[i], 16, (i == gbit) ? gc : -1);
        if (PAR) drive(^d ^ pflip, 16, -1);
        drive(stop, 16, -1);
        if (good) exp_data = d;
        exp_perr = perr;
        exp_ferr = ~stop;
        check({tag, ".valid_n"}, 32'(vcount - v0), good ? 32'd1 : 32'd0);
        if (good) check({tag, ".valid_tick"}, 32'(vtick), 32'(t_dec));
        check_outputs(tag);
        drive(1'b1, idle, -1);
    endtask

    initial begin
        logic [7:0] d;
        bit         pf, st;
        int         gb, gcnt, v0;

        rst = 1'b0; Rx_EN = 1'b1; RxD = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(Rx_VALID), 32'd0);
        check_outputs("rst");
        rst = 1'b1;
        drive(1'b1, 4, -1);

        frame(8'hA5, 1'b0, 1'b1, -1, -1, 3, "clean_a5");
        div = 4;
        if (PAR) begin
            frame(8'h01, 1'b1, 1'b1, -1, -1, 3, "perr_01");
            frame(8'h3C, 1'b0, 1'b1, -1, -1, 3, "good_3c");
        end

        // framing error followed by a long break
        frame(8'h55, 1'b0, 1'b0, -1, -1, 0, "ferr_55");
        v0 = vcount;
        drive(1'b0, 640, -1);
        check("break.valid_n", 32'(vcount - v0), 32'd0);
        check_outputs("break");
        drive(1'b1, 2, -1);
        frame(8'h0F, 1'b0, 1'b1, -1, -1, 3, "after_break_0f");

        // runt low pulse on an idle line is a false start
        v0 = vcount;
        drive(1'b0, 3, -1);
        drive(1'b1, 13, -1);
        check("runt.valid_n", 32'(vcount - v0), 32'd0);
        check_outputs("runt");
        frame(8'hF0, 1'b0, 1'b1, 5, 8, 3, "glitch_f0");
        frame(8'hC3, 1'b0, 1'b1, -1, -1, 3, "good_c3");

        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom);
            pf   = PAR && ($urandom_range(3) == 0);
            st   = ($urandom_range(3) != 0);
            gb   = ($urandom_range(1) == 1) ? int'($urandom_range(7)) : -1;
            gcnt = int'($urandom_range(15));
            div  = int'($urandom_range(6, 3));
            frame(d, pf, st, gb, gcnt, 3, "rnd");
        end
        div = 4;
        frame(8'h5A, 1'b0, 1'b1, -1, -1, 3, "good_5a");

        // Rx_EN dropped in the middle of data bit 4, right before a tick
        v0 = vcount;
        d = 8'h96;
        drive(1'b0, 16, -1);
        for (int i = 0; i < 4; i++) drive(d[i], 16, -1);
        drive(d[4], 5, -1);
        Rx_EN = 1'b0;
        drive(d[4], 11, -1);
        for (int i = 5; i < 8; i++) drive(d[i], 16, -1);
        if (PAR) drive(^d, 16, -1);
        drive(1'b1, 19, -1);
        Rx_EN = 1'b1;
        drive(1'b1, 3, -1);
        check("abort.valid_n", 32'(vcount - v0), 32'd0);
        check_outputs("abort");
        frame(8'h69, 1'b0, 1'b1, -1, -1, 3, "after_abort_69");

        // asynchronous reset in the middle of a frame
        drive(1'b0, 16, -1);
        drive(1'b1, 16, -1);
        drive(1'b0, 7, -1);
        #3;
        rst = 1'b0;
        #1;
        exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0;
        check("midrst.valid", 32'(Rx_VALID), 32'd0);
        check_outputs("midrst");
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        v0 = vcount;
        drive(1'b1, 200, -1);
        check("postrst.valid_n", 32'(vcount - v0), 32'd0);
        check_outputs("postrst");
        frame(8'hC3, 1'b0, 1'b1, -1, -1, 3, "final_c3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
